// File: rtl/mac_sequencer_if.sv
// Operand and result valid/ready streams between the sequencer and its neighbours.
// The sequencer is the slave of the operand stream and the master of the result stream.
interface mac_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_a;
  logic [DATA_WIDTH-1:0]     in_b;
  logic                      res_valid;
  logic                      res_ready;
  logic [3*DATA_WIDTH-1:0]   res_data;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences clear/enable pulses into a one-cycle-delayed MAC to compute fixed-length
// dot products, then holds the captured sum on a valid/ready result port.
module mac_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort_i,
  mac_sequencer_if.slave          s_if,
  output logic                    mac_en_o,
  output logic                    mac_clr_o,
  output logic [DATA_WIDTH-1:0]   mac_a_o,
  output logic [DATA_WIDTH-1:0]   mac_b_o,
  input  logic [3*DATA_WIDTH-1:0] mac_c_i
);

  localparam int CntW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    StClr,
    StFeed,
    StFlush,
    StWait,
    StOut
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [3*DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                    in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClr;
      count_q    <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      res_data_q <= res_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    res_data_d = res_data_q;
    in_ready   = 1'b0;
    mac_en_o   = 1'b0;
    mac_clr_o  = 1'b0;
    mac_a_o    = '0;
    mac_b_o    = '0;
    unique case (state_q)
      StClr: begin
        mac_clr_o = 1'b1;
        count_d   = '0;
        state_d   = StFeed;
      end
      StFeed: begin
        in_ready = !abort_i;
        if (s_if.in_valid && in_ready) begin
          mac_en_o = 1'b1;
          mac_a_o  = s_if.in_a;
          mac_b_o  = s_if.in_b;
          if (count_q == LastIdx) begin
            state_d = StFlush;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      // Zero operands push the last registered product into the accumulator.
      StFlush: begin
        mac_en_o = !abort_i;
        state_d  = StWait;
      end
      StWait: begin
        res_data_d = mac_c_i;
        state_d    = StOut;
      end
      StOut: begin
        if (s_if.res_ready) begin
          state_d = StClr;
        end
      end
      default: state_d = StClr;
    endcase
    if (abort_i) begin
      state_d = StClr;
    end
  end

  assign s_if.in_ready  = in_ready;
  assign s_if.res_valid = (state_q == StOut);
  assign s_if.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: a VEC_LEN=4 and a VEC_LEN=1 instance, each driving
// a behavioural MAC, with results checked against plain dot-product arithmetic.
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort4 = 1'b0;
  logic abort1 = 1'b0;
  int   cyc = 0;
  int   nVec = 0;
  int   nErr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_sequencer_if #(.DATA_WIDTH(8)) bus4 ();
  mac_sequencer_if #(.DATA_WIDTH(8)) bus1 ();

  logic        mac_en4, mac_clr4, mac_en1, mac_clr1;
  logic [7:0]  mac_a4, mac_b4, mac_a1, mac_b1;
  logic [15:0] p4 = '0, p1 = '0;
  logic [23:0] acc4 = '0, acc1 = '0;
  logic [23:0] mac_c4, mac_c1;

  mac_sequencer #(.DATA_WIDTH(8), .VEC_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .abort_i(abort4), .s_if(bus4.slave),
    .mac_en_o(mac_en4), .mac_clr_o(mac_clr4), .mac_a_o(mac_a4), .mac_b_o(mac_b4),
    .mac_c_i(mac_c4)
  );

  mac_sequencer #(.DATA_WIDTH(8), .VEC_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .abort_i(abort1), .s_if(bus1.slave),
    .mac_en_o(mac_en1), .mac_clr_o(mac_clr1), .mac_a_o(mac_a1), .mac_b_o(mac_b1),
    .mac_c_i(mac_c1)
  );

  // MAC: product registered on enable, previous product added to the accumulator on the same edge.
  always @(posedge clk) begin
    if (mac_clr4) begin
      p4 <= '0; acc4 <= '0;
    end else if (mac_en4) begin
      p4 <= mac_a4 * mac_b4; acc4 <= acc4 + 24'(p4);
    end
    if (mac_clr1) begin
      p1 <= '0; acc1 <= '0;
    end else if (mac_en1) begin
      p1 <= mac_a1 * mac_b1; acc1 <= acc1 + 24'(p1);
    end
  end
  assign mac_c4 = acc4;
  assign mac_c1 = acc1;

  logic [7:0]  va [4];
  logic [7:0]  vb [4];
  logic [23:0] rGot;
  int rLat, rEn, rClr, rHoldBad, rValidCycles, rZeroBad, rSpan, rTurn;
  bit rTimeout;

  function automatic int dotRef();
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(va[i]) * int'(vb[i]);
    return s;
  endfunction

  task automatic setVec(input int a0, a1, a2, a3, b0, b1, b2, b3);
    va[0] = 8'(a0); va[1] = 8'(a1); va[2] = 8'(a2); va[3] = 8'(a3);
    vb[0] = 8'(b0); vb[1] = 8'(b1); vb[2] = 8'(b2); vb[3] = 8'(b3);
  endtask

  // Drives va/vb from FEED through acceptance and the following clear, recording observations.
  task automatic runVec(input bit bubbles, input int holdRes);
    int idx = 0, firstHs = -1, lastHs = -1, resCyc = -1, accCyc = -1;
    bit phase = 1'b0, seen = 1'b0, accepted = 1'b0;
    logic [23:0] firstData = '0;
    rEn = 0; rClr = 0; rHoldBad = 0; rValidCycles = 0; rZeroBad = 0;
    rTurn = -1; rTimeout = 1'b0; rGot = 'x;
    for (int k = 0; k < 200 && rTurn < 0; k++) begin
      bus4.in_valid = (idx < 4) && (!bubbles || !phase);
      if (idx < 4) begin
        bus4.in_a = va[idx]; bus4.in_b = vb[idx];
      end else begin
        bus4.in_a = 8'($urandom); bus4.in_b = 8'($urandom);
      end
      bus4.res_ready = (rValidCycles >= holdRes);
      @(negedge clk);
      if (mac_clr4) rClr++;
      if (mac_en4) rEn++;
      if (!mac_en4 && (mac_a4 !== 8'd0 || mac_b4 !== 8'd0)) rZeroBad++;
      if (accepted && bus4.in_ready) rTurn = cyc - accCyc;
      if (bus4.in_valid && bus4.in_ready) begin
        if (firstHs < 0) firstHs = cyc;
        lastHs = cyc;
        idx++;
      end
      if (bus4.res_valid && !accepted) begin
        if (!seen) begin
          seen = 1'b1; resCyc = cyc; firstData = bus4.res_data;
        end else if (bus4.res_data !== firstData) begin
          rHoldBad++;
        end
        rValidCycles++;
        if (bus4.res_ready) begin
          accepted = 1'b1; accCyc = cyc; rGot = bus4.res_data;
        end
      end
      @(posedge clk); #1;
      phase = ~phase;
    end
    if (rTurn < 0) rTimeout = 1'b1;
    rLat  = resCyc - lastHs;
    rSpan = lastHs - firstHs;
    bus4.in_valid = 1'b0;
    bus4.res_ready = 1'b0;
  endtask

  // Feeds va/vb back-to-back with the result held off; returns while the sequencer sits in OUT.
  task automatic feedUntilResult(output bit ok);
    int idx = 0;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      bus4.in_valid = (idx < 4);
      if (idx < 4) begin
        bus4.in_a = va[idx]; bus4.in_b = vb[idx];
      end
      bus4.res_ready = 1'b0;
      @(negedge clk);
      if (bus4.in_valid && bus4.in_ready) idx++;
      if (bus4.res_valid) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus4.in_valid = 1'b1; bus4.in_a = 8'd9; bus4.in_b = 8'd9; bus4.res_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.res_ready = 1'b1;
    @(negedge clk);
    nVec++; if (bus4.res_valid !== 1'b0) begin nErr++; $display("[TB] FAIL rst_res_valid got=%0b exp=0", bus4.res_valid); end
    nVec++; if (bus4.res_data !== 24'd0) begin nErr++; $display("[TB] FAIL rst_res_data got=%0d exp=0", bus4.res_data); end
    nVec++; if (bus4.in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL rst_in_ready got=%0b exp=0", bus4.in_ready); end
    nVec++; if (mac_en4 !== 1'b0) begin nErr++; $display("[TB] FAIL rst_mac_en got=%0b exp=0", mac_en4); end
    nVec++; if (mac_clr4 !== 1'b1) begin nErr++; $display("[TB] FAIL rst_mac_clr got=%0b exp=1", mac_clr4); end
    nVec++; if ({mac_a4, mac_b4} !== 16'd0) begin nErr++; $display("[TB] FAIL rst_mac_ab got=%0h exp=0", {mac_a4, mac_b4}); end
    nVec++; if (mac_clr1 !== 1'b1) begin nErr++; $display("[TB] FAIL rst_mac_clr_v1 got=%0b exp=1", mac_clr1); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    @(negedge clk);
    nVec++; if (mac_clr4 !== 1'b1) begin nErr++; $display("[TB] FAIL post_rst_clr got=%0b exp=1", mac_clr4); end
    nVec++; if (bus4.in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL post_rst_ready0 got=%0b exp=0", bus4.in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    nVec++; if (bus4.in_ready !== 1'b1) begin nErr++; $display("[TB] FAIL post_rst_ready1 got=%0b exp=1", bus4.in_ready); end
    nVec++; if (mac_clr4 !== 1'b0) begin nErr++; $display("[TB] FAIL post_rst_clr_off got=%0b exp=0", mac_clr4); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    setVec(1, 2, 3, 4, 5, 6, 7, 8);
    runVec(1'b0, 0);
    nVec++; if (rTimeout) begin nErr++; $display("[TB] FAIL basic_timeout got=1 exp=0"); end
    nVec++; if (rGot !== 24'(dotRef())) begin nErr++; $display("[TB] FAIL basic_sum got=%0d exp=%0d", rGot, dotRef()); end
    nVec++; if (rLat !== 3) begin nErr++; $display("[TB] FAIL basic_latency got=%0d exp=3", rLat); end
    nVec++; if (rSpan !== 3) begin nErr++; $display("[TB] FAIL basic_throughput got=%0d exp=3", rSpan); end
    nVec++; if (rEn !== 5) begin nErr++; $display("[TB] FAIL basic_en_count got=%0d exp=5", rEn); end
    nVec++; if (rClr !== 1) begin nErr++; $display("[TB] FAIL basic_clr_count got=%0d exp=1", rClr); end
    nVec++; if (rTurn !== 2) begin nErr++; $display("[TB] FAIL basic_turnaround got=%0d exp=2", rTurn); end
  endtask

  task automatic test_bubbles();
    setVec(1, 2, 3, 4, 5, 6, 7, 8);
    runVec(1'b1, 5);
    nVec++; if (rTimeout) begin nErr++; $display("[TB] FAIL bub_timeout got=1 exp=0"); end
    nVec++; if (rGot !== 24'd70) begin nErr++; $display("[TB] FAIL bub_sum got=%0d exp=70", rGot); end
    nVec++; if (rHoldBad !== 0) begin nErr++; $display("[TB] FAIL bub_hold_stable got=%0d exp=0", rHoldBad); end
    nVec++; if (rValidCycles !== 6) begin nErr++; $display("[TB] FAIL bub_valid_cycles got=%0d exp=6", rValidCycles); end
    nVec++; if (rEn !== 5) begin nErr++; $display("[TB] FAIL bub_en_count got=%0d exp=5", rEn); end
    nVec++; if (rZeroBad !== 0) begin nErr++; $display("[TB] FAIL bub_idle_operands got=%0d exp=0", rZeroBad); end
    nVec++; if (rLat !== 3) begin nErr++; $display("[TB] FAIL bub_latency got=%0d exp=3", rLat); end
  endtask

  task automatic test_max_values();
    setVec(255, 255, 255, 255, 255, 255, 255, 255);
    runVec(1'b0, 0);
    nVec++; if (rGot !== 24'(dotRef()) || rTimeout) begin nErr++; $display("[TB] FAIL max_sum got=%0d exp=%0d", rGot, dotRef()); end
    setVec(1, 1, 1, 1, 1, 1, 1, 1);
    runVec(1'b0, 0);
    nVec++; if (rGot !== 24'd4 || rTimeout) begin nErr++; $display("[TB] FAIL max_then_ones got=%0d exp=4", rGot); end
  endtask

  task automatic test_random();
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        va[i] = 8'($urandom_range(0, 255));
        vb[i] = 8'($urandom_range(0, 255));
      end
      runVec(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      nVec++; if (rGot !== 24'(dotRef()) || rTimeout) begin nErr++; $display("[TB] FAIL rand_sum[%0d] got=%0d exp=%0d", v, rGot, dotRef()); end
      nVec++; if (rLat !== 3 || rHoldBad !== 0 || rZeroBad !== 0) begin nErr++; $display("[TB] FAIL rand_timing[%0d] got=lat%0d/hold%0d/zero%0d exp=lat3/hold0/zero0", v, rLat, rHoldBad, rZeroBad); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    setVec(9, 9, 9, 9, 9, 9, 9, 9);
    for (int i = 0; i < 2; i++) begin
      bus4.in_valid = 1'b1; bus4.in_a = va[i]; bus4.in_b = vb[i];
      @(negedge clk);
      @(posedge clk); #1;
    end
    abort4 = 1'b1; bus4.in_a = va[2]; bus4.in_b = vb[2];
    @(negedge clk);
    nVec++; if (bus4.in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL abort_in_ready got=%0b exp=0", bus4.in_ready); end
    nVec++; if (mac_en4 !== 1'b0) begin nErr++; $display("[TB] FAIL abort_mac_en got=%0b exp=0", mac_en4); end
    @(posedge clk); #1;
    abort4 = 1'b0; bus4.in_valid = 1'b0;
    @(negedge clk);
    nVec++; if (mac_clr4 !== 1'b1 || bus4.res_valid !== 1'b0) begin nErr++; $display("[TB] FAIL abort_to_clr got=clr%0b/valid%0b exp=clr1/valid0", mac_clr4, bus4.res_valid); end
    @(posedge clk); #1;
    setVec(1, 2, 3, 4, 5, 6, 7, 8);
    runVec(1'b0, 0);
    nVec++; if (rGot !== 24'd70 || rTimeout) begin nErr++; $display("[TB] FAIL abort_next_sum got=%0d exp=70", rGot); end
    feedUntilResult(ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL abort_out_reach got=0 exp=1"); end
    abort4 = 1'b1;
    @(posedge clk); #1;
    abort4 = 1'b0;
    @(negedge clk);
    nVec++; if (bus4.res_valid !== 1'b0 || mac_clr4 !== 1'b1) begin nErr++; $display("[TB] FAIL abort_out_drop got=valid%0b/clr%0b exp=valid0/clr1", bus4.res_valid, mac_clr4); end
    @(posedge clk); #1;
    setVec(3, 0, 7, 2, 11, 4, 1, 6);
    runVec(1'b0, 0);
    nVec++; if (rGot !== 24'(dotRef()) || rTimeout) begin nErr++; $display("[TB] FAIL abort_out_next got=%0d exp=%0d", rGot, dotRef()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    setVec(1, 2, 3, 4, 5, 6, 7, 8);
    for (int i = 0; i < 2; i++) begin
      bus4.in_valid = 1'b1; bus4.in_a = va[i]; bus4.in_b = vb[i];
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    nVec++; if (bus4.in_ready !== 1'b0 || mac_en4 !== 1'b0 || mac_clr4 !== 1'b1) begin nErr++; $display("[TB] FAIL rstmid_feed got=rdy%0b/en%0b/clr%0b exp=rdy0/en0/clr1", bus4.in_ready, mac_en4, mac_clr4); end
    nVec++; if ({mac_a4, mac_b4} !== 16'd0) begin nErr++; $display("[TB] FAIL rstmid_ab got=%0h exp=0", {mac_a4, mac_b4}); end
    @(posedge clk); #1;
    rst = 1'b0; bus4.in_valid = 1'b0;
    @(negedge clk);
    nVec++; if (mac_clr4 !== 1'b1) begin nErr++; $display("[TB] FAIL rstmid_clr_cycle got=%0b exp=1", mac_clr4); end
    @(posedge clk); #1;
    runVec(1'b0, 0);
    nVec++; if (rGot !== 24'd70 || rTimeout) begin nErr++; $display("[TB] FAIL rstmid_next_sum got=%0d exp=70", rGot); end
    feedUntilResult(ok);
    nVec++; if (!ok) begin nErr++; $display("[TB] FAIL rstout_reach got=0 exp=1"); end
    rst = 1'b1;
    #1;
    nVec++; if (bus4.res_valid !== 1'b0 || bus4.res_data !== 24'd0) begin nErr++; $display("[TB] FAIL rstout_outputs got=valid%0b/data%0d exp=valid0/data0", bus4.res_valid, bus4.res_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    nVec++; if (mac_clr4 !== 1'b1) begin nErr++; $display("[TB] FAIL rstout_clr_cycle got=%0b exp=1", mac_clr4); end
    @(posedge clk); #1;
    setVec(200, 17, 0, 99, 3, 250, 77, 128);
    runVec(1'b1, 2);
    nVec++; if (rGot !== 24'(dotRef()) || rTimeout) begin nErr++; $display("[TB] FAIL rstout_next_sum got=%0d exp=%0d", rGot, dotRef()); end
  endtask

  task automatic test_veclen1();
    int a, b, hsCyc, resCyc;
    logic [23:0] got;
    for (int v = 0; v < 3; v++) begin
      a = (v == 0) ? 12 : int'($urandom_range(0, 255));
      b = (v == 0) ? 10 : int'($urandom_range(0, 255));
      hsCyc = -1; resCyc = -1; got = 'x;
      bus1.in_a = 8'(a); bus1.in_b = 8'(b); bus1.res_ready = 1'b1;
      for (int k = 0; k < 20 && resCyc < 0; k++) begin
        bus1.in_valid = (hsCyc < 0);
        @(negedge clk);
        if (bus1.in_valid && bus1.in_ready) hsCyc = cyc;
        if (bus1.res_valid) begin
          resCyc = cyc; got = bus1.res_data;
        end
        @(posedge clk); #1;
      end
      bus1.in_valid = 1'b0;
      nVec++; if (got !== 24'(a * b)) begin nErr++; $display("[TB] FAIL v1_product[%0d] got=%0d exp=%0d", v, got, a * b); end
      nVec++; if (hsCyc < 0 || resCyc - hsCyc !== 3) begin nErr++; $display("[TB] FAIL v1_latency[%0d] got=%0d exp=3", v, resCyc - hsCyc); end
    end
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.res_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_max_values();
    test_random();
    test_abort();
    test_reset_mid();
    test_veclen1();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
